// File: rtl/solver_feeder_pkg.sv
// Shared types and default widths for the solver feeder: FSM state encoding
// and the limb/tag geometry used by the solver top level.
package solver_feeder_pkg;

  localparam int DEF_LIMB_INDEX_BITS = 6;
  localparam int DEF_LIMB_SIZE_BITS  = 27;
  localparam int DEF_TAG_BITS        = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CFG    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESULT = 3'd5
  } state_t;

endpackage

// File: rtl/solver_feeder.sv
// Accepts a job header plus its c limbs, loads them into the solver, starts it,
// waits for a fresh done level and returns a tagged iteration count.
module solver_feeder
  import solver_feeder_pkg::*;
#(
  parameter int LIMB_INDEX_BITS = DEF_LIMB_INDEX_BITS,
  parameter int LIMB_SIZE_BITS  = DEF_LIMB_SIZE_BITS,
  parameter int TAG_BITS        = DEF_TAG_BITS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
  input  logic [15:0]                job_iter_lim,
  input  logic [TAG_BITS-1:0]        job_tag,
  input  logic                       limb_valid,
  output logic                       limb_ready,
  input  logic [LIMB_SIZE_BITS-1:0]  limb_re,
  input  logic [LIMB_SIZE_BITS-1:0]  limb_im,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_index,
  output logic [LIMB_SIZE_BITS-1:0]  real_data,
  output logic [LIMB_SIZE_BITS-1:0]  imag_data,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [15:0]                iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [15:0]                iterations,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TAG_BITS-1:0]        res_tag,
  output logic [15:0]                res_iterations,
  output logic                       res_error,
  output logic                       busy
);

  state_t                     state_r;
  state_t                     state_n;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_r;
  logic [15:0]                iter_lim_r;
  logic [TAG_BITS-1:0]        tag_r;
  logic [LIMB_INDEX_BITS-1:0] count_r;
  logic                       armed_r;
  logic [TAG_BITS-1:0]        res_tag_r;
  logic [15:0]                res_iter_r;
  logic                       res_error_r;
  logic                       last_limb_s;

  assign last_limb_s    = (count_r == (num_limbs_r - LIMB_INDEX_BITS'(1)));
  assign wr_index       = count_r;
  assign num_limbs_data = num_limbs_r;
  assign iter_lim_data  = iter_lim_r;
  assign res_tag        = res_tag_r;
  assign res_iterations = res_iter_r;
  assign res_error      = res_error_r;
  assign busy           = (state_r != ST_IDLE);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and strobe decode; all strobes derive from one state so they cannot overlap
  always_comb begin
    state_n         = state_r;
    job_ready       = 1'b0;
    limb_ready      = 1'b0;
    wr_real_en      = 1'b0;
    wr_imag_en      = 1'b0;
    real_data       = '0;
    imag_data       = '0;
    wr_num_limbs_en = 1'b0;
    wr_iter_lim_en  = 1'b0;
    start           = 1'b0;
    res_valid       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          state_n = (job_num_limbs == '0) ? ST_RESULT : ST_CFG;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CFG: begin
        wr_num_limbs_en = 1'b1;
        wr_iter_lim_en  = 1'b1;
        state_n         = ST_LOAD;
      end
      ST_LOAD: begin
        limb_ready = 1'b1;
        wr_real_en = limb_valid;
        wr_imag_en = limb_valid;
        real_data  = limb_re;
        imag_data  = limb_im;
        if (limb_valid && last_limb_s) begin
          state_n = ST_START;
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_START: begin
        start   = 1'b1;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // Only a done level seen after a low phase belongs to this job
        if (armed_r && out_ready) begin
          state_n = ST_RESULT;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_RESULT;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Job latch, limb counter, re-arm flag and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      num_limbs_r <= '0;
      iter_lim_r  <= '0;
      tag_r       <= '0;
      count_r     <= '0;
      armed_r     <= 1'b0;
      res_tag_r   <= '0;
      res_iter_r  <= '0;
      res_error_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (job_valid) begin
            num_limbs_r <= job_num_limbs;
            iter_lim_r  <= job_iter_lim;
            tag_r       <= job_tag;
            if (job_num_limbs == '0) begin
              res_tag_r   <= job_tag;
              res_iter_r  <= 16'd0;
              res_error_r <= 1'b1;
            end
          end
        end
        ST_CFG: begin
          count_r <= '0;
        end
        ST_LOAD: begin
          if (limb_valid) begin
            count_r <= count_r + LIMB_INDEX_BITS'(1);
          end
        end
        ST_START: begin
          armed_r <= 1'b0;
        end
        ST_WAIT: begin
          if (!out_ready) begin
            armed_r <= 1'b1;
          end else if (armed_r) begin
            res_tag_r   <= tag_r;
            res_iter_r  <= iterations;
            res_error_r <= 1'b0;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solver_feeder.sv
// Directed bench for solver_feeder: drives jobs/limbs, plays the solver's
// done/iterations levels and checks write logs and results against hand values.
module tb_solver_feeder;

  logic        clock;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [5:0]  job_num_limbs;
  logic [15:0] job_iter_lim;
  logic [15:0] job_tag;
  logic        limb_valid;
  logic        limb_ready;
  logic [26:0] limb_re;
  logic [26:0] limb_im;
  logic        wr_real_en;
  logic        wr_imag_en;
  logic [5:0]  wr_index;
  logic [26:0] real_data;
  logic [26:0] imag_data;
  logic        wr_num_limbs_en;
  logic [5:0]  num_limbs_data;
  logic        wr_iter_lim_en;
  logic [15:0] iter_lim_data;
  logic        start;
  logic        out_ready;
  logic [15:0] iterations;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_tag;
  logic [15:0] res_iterations;
  logic        res_error;
  logic        busy;

  int checks = 0;
  int failures = 0;

  int          wr_count = 0;
  int          cfg_count = 0;
  int          start_count = 0;
  int          excl_viol = 0;
  logic [5:0]  cfg_nl;
  logic [15:0] cfg_il;
  logic [5:0]  log_idx [64];
  logic [26:0] log_re  [64];
  logic [26:0] log_im  [64];

  solver_feeder dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_num_limbs(job_num_limbs), .job_iter_lim(job_iter_lim), .job_tag(job_tag),
    .limb_valid(limb_valid), .limb_ready(limb_ready),
    .limb_re(limb_re), .limb_im(limb_im),
    .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en), .wr_index(wr_index),
    .real_data(real_data), .imag_data(imag_data),
    .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
    .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
    .start(start), .out_ready(out_ready), .iterations(iterations),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_iterations(res_iterations), .res_error(res_error),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Solver-side log, sampled mid-cycle when inputs and strobes are settled
  always @(negedge clock) begin
    int groups;
    groups = 0;
    if (wr_real_en || wr_imag_en) groups++;
    if (wr_num_limbs_en || wr_iter_lim_en) groups++;
    if (start) groups++;
    if (groups > 1 || (wr_real_en != wr_imag_en) || (wr_num_limbs_en != wr_iter_lim_en))
      excl_viol++;
    if (wr_real_en) begin
      log_idx[wr_count & 63] = wr_index;
      log_re[wr_count & 63]  = real_data;
      log_im[wr_count & 63]  = imag_data;
      wr_count++;
    end
    if (wr_num_limbs_en) begin
      cfg_nl = num_limbs_data;
      cfg_il = iter_lim_data;
      cfg_count++;
    end
    if (start) start_count++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_job(input logic [5:0] nl, input logic [15:0] il, input logic [15:0] tg);
    int n;
    n = 0;
    job_num_limbs = nl;
    job_iter_lim  = il;
    job_tag       = tg;
    job_valid     = 1'b1;
    while (!job_ready && n < 100) begin
      tick();
      n++;
    end
    chk("job_accept_timeout", 32'(n < 100), 32'd1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic send_limb(input logic [26:0] re, input logic [26:0] im, input int gap);
    int n;
    n = 0;
    repeat (gap) tick();
    limb_re    = re;
    limb_im    = im;
    limb_valid = 1'b1;
    while (!limb_ready && n < 100) begin
      tick();
      n++;
    end
    chk("limb_accept_timeout", 32'(n < 100), 32'd1);
    tick();
    limb_valid = 1'b0;
  endtask

  task automatic wait_start;
    int n;
    n = 0;
    while (!start && n < 100) begin
      tick();
      n++;
    end
    chk("start_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic wait_res;
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    chk("result_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic take_res;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int base_wr, base_cfg, base_st, early;
    reset = 1'b0;
    job_valid = 1'b0; job_num_limbs = '0; job_iter_lim = '0; job_tag = '0;
    limb_valid = 1'b0; limb_re = '0; limb_im = '0;
    out_ready = 1'b0; iterations = '0; res_ready = 1'b0;
    repeat (3) tick();

    chk("rst_busy", busy, 1'b0);
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_limb_ready", limb_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_iter", res_iterations, 16'd0);
    chk("rst_strobes", {wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en, start}, 5'd0);
    reset = 1'b1;
    tick();

    // Back-to-back limbs, solver returns 57
    base_wr = wr_count; base_cfg = cfg_count; base_st = start_count;
    send_job(6'd3, 16'd100, 16'h0042);
    chk("t1_cfg_strobe", {wr_num_limbs_en, wr_iter_lim_en}, 2'b11);
    chk("t1_cfg_job_ready", job_ready, 1'b0);
    chk("t1_cfg_limb_ready", limb_ready, 1'b0);
    send_limb(27'd1, 27'd2, 0);
    send_limb(27'd3, 27'd4, 0);
    send_limb(27'd5, 27'd6, 0);
    wait_start();
    tick();
    chk("t1_start_one_cycle", start, 1'b0);
    tick();
    iterations = 16'd57;
    out_ready  = 1'b1;
    wait_res();
    chk("t1_cfg_count", 32'(cfg_count - base_cfg), 32'd1);
    chk("t1_cfg_nl", cfg_nl, 6'd3);
    chk("t1_cfg_il", cfg_il, 16'd100);
    chk("t1_wr_count", 32'(wr_count - base_wr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_wr_idx", log_idx[(base_wr + i) & 63], 32'(i));
      chk("t1_wr_re", log_re[(base_wr + i) & 63], 32'(2 * i + 1));
      chk("t1_wr_im", log_im[(base_wr + i) & 63], 32'(2 * i + 2));
    end
    chk("t1_start_count", 32'(start_count - base_st), 32'd1);
    chk("t1_res_tag", res_tag, 16'h0042);
    chk("t1_res_iter", res_iterations, 16'd57);
    chk("t1_res_err", res_error, 1'b0);
    take_res();
    chk("t1_idle", busy, 1'b0);

    // Same job with 2-cycle gaps; out_ready still high from job 1
    base_wr = wr_count; base_st = start_count;
    send_job(6'd3, 16'd100, 16'h0042);
    send_limb(27'd1, 27'd2, 2);
    send_limb(27'd3, 27'd4, 2);
    send_limb(27'd5, 27'd6, 2);
    wait_start();
    tick();
    out_ready = 1'b0;
    repeat (2) tick();
    out_ready = 1'b1;
    wait_res();
    chk("t2_wr_count", 32'(wr_count - base_wr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_wr_idx", log_idx[(base_wr + i) & 63], 32'(i));
      chk("t2_wr_re", log_re[(base_wr + i) & 63], 32'(2 * i + 1));
      chk("t2_wr_im", log_im[(base_wr + i) & 63], 32'(2 * i + 2));
    end
    chk("t2_start_count", 32'(start_count - base_st), 32'd1);
    chk("t2_res_iter", res_iterations, 16'd57);
    take_res();

    // Stale done level must not complete the job
    iterations = 16'd123;
    send_job(6'd2, 16'd50, 16'h0123);
    send_limb(27'd10, 27'd20, 0);
    send_limb(27'd30, 27'd40, 0);
    wait_start();
    early = 0;
    repeat (3) begin
      tick();
      if (res_valid) early++;
    end
    out_ready  = 1'b0;
    iterations = 16'd9;
    repeat (10) begin
      tick();
      if (res_valid) early++;
    end
    chk("t3_no_early_done", 32'(early), 32'd0);
    chk("t3_busy_waiting", busy, 1'b1);
    out_ready = 1'b1;
    wait_res();
    chk("t3_res_iter", res_iterations, 16'd9);
    chk("t3_res_tag", res_tag, 16'h0123);
    take_res();

    // Zero-limb job is an error with no solver activity
    base_wr = wr_count; base_cfg = cfg_count; base_st = start_count;
    send_job(6'd0, 16'd10, 16'h0007);
    wait_res();
    chk("t4_res_err", res_error, 1'b1);
    chk("t4_res_iter", res_iterations, 16'd0);
    chk("t4_res_tag", res_tag, 16'h0007);
    chk("t4_no_writes", 32'(wr_count - base_wr), 32'd0);
    chk("t4_no_cfg", 32'(cfg_count - base_cfg), 32'd0);
    chk("t4_no_start", 32'(start_count - base_st), 32'd0);

    // Result back-pressure with the next job already waiting
    job_num_limbs = 6'd1; job_iter_lim = 16'd5; job_tag = 16'h0055; job_valid = 1'b1;
    early = 0;
    repeat (5) begin
      tick();
      if (!res_valid || res_tag !== 16'h0007 || res_error !== 1'b1 ||
          res_iterations !== 16'd0 || job_ready !== 1'b0) early++;
    end
    chk("t5_res_stable", 32'(early), 32'd0);
    take_res();
    chk("t5_job_ready_after", job_ready, 1'b1);
    tick();
    job_valid = 1'b0;
    chk("t5_next_cfg", wr_num_limbs_en, 1'b1);
    send_limb(27'd77, 27'd88, 0);
    wait_start();
    tick();
    out_ready = 1'b0;
    tick();
    iterations = 16'd3;
    out_ready  = 1'b1;
    wait_res();
    chk("t5_res_tag", res_tag, 16'h0055);
    chk("t5_res_iter", res_iterations, 16'd3);
    take_res();

    // Reset in the middle of LOAD
    send_job(6'd3, 16'd100, 16'h0033);
    send_limb(27'd1, 27'd2, 0);
    send_limb(27'd3, 27'd4, 0);
    limb_re = 27'd7; limb_im = 27'd8; limb_valid = 1'b1;
    #1;
    chk("t6_pre_rst_strobe", wr_real_en, 1'b1);
    reset = 1'b0;
    #1;
    chk("t6_rst_strobes", {wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en, start}, 5'd0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_limb_ready", limb_ready, 1'b0);
    chk("t6_rst_index", wr_index, 6'd0);
    chk("t6_rst_data", {real_data, imag_data}, 54'd0);
    chk("t6_rst_res", {res_valid, res_tag, res_iterations, res_error}, 34'd0);
    limb_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    base_wr = wr_count;
    send_job(6'd1, 16'd8, 16'h0099);
    send_limb(27'd11, 27'd12, 0);
    wait_start();
    tick();
    out_ready = 1'b0;
    tick();
    iterations = 16'd20;
    out_ready  = 1'b1;
    wait_res();
    chk("t6_wr_count", 32'(wr_count - base_wr), 32'd1);
    chk("t6_wr_idx", log_idx[base_wr & 63], 6'd0);
    chk("t6_wr_re", log_re[base_wr & 63], 27'd11);
    chk("t6_res_tag", res_tag, 16'h0099);
    chk("t6_res_iter", res_iterations, 16'd20);
    take_res();

    chk("strobe_exclusive", 32'(excl_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/solver_feeder.md
SOLVER_FEEDER -- requirements
Module: solver_feeder

Interface
REQ-001 Parameter LIMB_INDEX_BITS, default 6, SHALL set the width of limb index and limb count.
REQ-002 Parameter LIMB_SIZE_BITS, default 27, SHALL set the width of one real or imaginary limb.
REQ-003 Parameter TAG_BITS, default 16, SHALL set the width of the job tag (pixel id).
REQ-004 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The ports SHALL be, in order:
- clock  in  1  rising-edge clock
- reset  in  1  async reset, asserted at 0
- job_valid / job_ready  in / out  1 each  job header handshake
- job_num_limbs  in  LIMB_INDEX_BITS  limbs per coordinate
- job_iter_lim  in  16  iteration limit
- job_tag  in  TAG_BITS  job id
- limb_valid / limb_ready  in / out  1 each  limb handshake
- limb_re, limb_im  in  LIMB_SIZE_BITS each  c limbs, index 0 first
- wr_real_en, wr_imag_en  out  1 each  solver limb write strobes
- wr_index  out  LIMB_INDEX_BITS  solver limb index
- real_data, imag_data  out  LIMB_SIZE_BITS each  solver limb data
- wr_num_limbs_en  out  1;  num_limbs_data  out  LIMB_INDEX_BITS
- wr_iter_lim_en  out  1;  iter_lim_data  out  16
- start  out  1  solver start pulse
- out_ready  in  1  solver done level
- iterations  in  16  solver count
- res_valid / res_ready  out / in  1 each  result handshake
- res_tag  out  TAG_BITS;  res_iterations  out  16;  res_error  out  1
- busy  out  1  high when not IDLE

Function
REQ-006 The FSM SHALL have states IDLE, CFG, LOAD, START, WAIT, RESULT.
REQ-007 IDLE: job_ready=1; on job_valid&job_ready, latch num_limbs, iter_lim and tag; go to CFG, or to RESULT with res_error=1 and res_iterations=0 if num_limbs==0.
REQ-008 CFG: last one cycle; assert wr_num_limbs_en and wr_iter_lim_en with the latched values; clear limb counter; go to LOAD.
REQ-009 LOAD: limb_ready=1; wr_real_en=wr_imag_en=limb_valid, wr_index=counter, real_data=limb_re, imag_data=limb_im (combinational passthrough, same cycle as handshake).
REQ-010 LOAD: counter SHALL increment per handshake; the handshake at counter==num_limbs-1 SHALL move to START. Stalls (limb_valid=0) SHALL hold state with strobes low.
REQ-011 START: assert start for exactly one cycle; clear armed flag; go to WAIT.
REQ-012 WAIT: set armed when out_ready==0; on armed&out_ready==1, capture iterations into res_iterations, res_error=0, go to RESULT.
REQ-013 A stale out_ready=1 from the previous job SHALL never complete WAIT before out_ready has been seen low.
REQ-014 RESULT: res_valid=1 with stable res_tag/res_iterations/res_error until res_ready; on handshake go to IDLE.
REQ-015 job_ready and limb_ready SHALL be 0 outside IDLE and LOAD respectively; limbs presented outside LOAD SHALL not be consumed.
REQ-016 All solver strobes (wr_*_en, start) SHALL be mutually exclusive in time except wr_real_en with wr_imag_en, and wr_num_limbs_en with wr_iter_lim_en.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 On reset low, state SHALL become IDLE asynchronously, with counter, armed, res_* and all strobes at 0, including mid-LOAD or mid-WAIT.
REQ-019 After reset release, the first accepted job SHALL start from CFG with counter 0.

Structure
REQ-020 A shared package SHALL hold the state enum and the default widths LIMB_INDEX_BITS, LIMB_SIZE_BITS and TAG_BITS.
REQ-021 No sub-module is required; solver_feeder SHALL sit beside solver in the top level and drive its load/start ports directly.

Verification
REQ-022 Job num_limbs=3, iter_lim=100, tag=0x0042, limbs (1,2),(3,4),(5,6) back-to-back -> CFG strobes once; writes at idx 0,1,2; start exactly 1 cycle; model solver returns 57 -> res tag 0x0042, iterations 57, error 0.
REQ-023 Same job with limb_valid gaps of 2 cycles -> identical solver write sequence, no strobe during gaps.
REQ-024 out_ready held 1 from the previous job, dropped 3 cycles after start, raised 10 cycles later with iterations=9 -> result 9, no early completion.
REQ-025 num_limbs=0, tag=0x0007 -> no solver strobes, res_error=1, res_iterations=0.
REQ-026 res_ready held 0 for 5 cycles -> res_* stable, job_ready stays 0; next job accepted only after the handshake.
REQ-027 Reset asserted after the 2nd limb write -> all outputs 0 immediately; a following 1-limb job completes normally with wr_index=0.
